countdown_timer_module: RTL and testbench

- Countdown engine for the hood's timed-run modes (e.g. delayed shutdown, self-clean). Loads a preset h:m:s, decrements once per second, pauses and resumes on request, and signals expiry.
- Sits directly upstream of the time display stage. It drives that stage's count_down_hour/min/sec and need_count_down inputs, and its done pulse goes to the mode controller.

---
 rtl/countdown_timer_module_pkg.sv | 25 ++
 rtl/countdown_timer_module_if.sv | 32 +++
 rtl/countdown_timer_module_hms_down_counter.sv | 82 ++++++++
 rtl/countdown_timer_module.sv | 124 ++++++++++++
 tb/tb_countdown_timer_module.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_module_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_module_pkg
// Shared definitions for the countdown timer and its sibling time counters
// (power-on and working-time counters).
//   state_e         : FSM state encoding (IDLE/RUN/PAUSE/DONE)
//   *_DEFAULT       : default prescale and minute/second ceiling
//   clamp_ms()      : saturates a minute/second value to the legal ceiling
// -----------------------------------------------------------------------------
package countdown_timer_module_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int TICKS_PER_SEC_DEFAULT = 500;
  localparam int MAX_MS_DEFAULT        = 59;

  function automatic logic [5:0] clamp_ms(input logic [5:0] v, input logic [5:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/countdown_timer_module_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_module_if
// Control/preset/status bundle between the mode controller side (master) and
// the countdown timer (slave).
//   start, abort, pause            : commands from the master
//   load_hour/min/sec              : preset, sampled only on start
//   count_down_hour/min/sec        : remaining time to the display stage
//   need_count_down, done          : activity level and expiry pulse
// -----------------------------------------------------------------------------
interface countdown_timer_module_if;
  logic       start;
  logic       abort;
  logic       pause;
  logic [5:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [5:0] count_down_hour;
  logic [5:0] count_down_min;
  logic [5:0] count_down_sec;
  logic       need_count_down;
  logic       done;

  modport master (
    output start, abort, pause, load_hour, load_min, load_sec,
    input  count_down_hour, count_down_min, count_down_sec, need_count_down, done
  );

  modport slave (
    input  start, abort, pause, load_hour, load_min, load_sec,
    output count_down_hour, count_down_min, count_down_sec, need_count_down, done
  );
endinterface

// File: rtl/countdown_timer_module_hms_down_counter.sv
// -----------------------------------------------------------------------------
// countdown_timer_module_hms_down_counter (hms_down_counter)
// Holds the hour/minute/second registers of the countdown.
//   clk_500Hz, rst_n : clock, synchronous active-low reset
//   clear            : zero all fields (highest priority)
//   load             : load preset, minutes/seconds clamped to MAX_MS
//   dec              : one-second decrement with borrow chain
//   hour/min/sec     : registered time
//   is_zero, is_one  : time is 00:00:00 / 00:00:01
// -----------------------------------------------------------------------------
module countdown_timer_module_hms_down_counter
  import countdown_timer_module_pkg::*;
#(
  parameter int MAX_MS = MAX_MS_DEFAULT
) (
  input  logic       clk_500Hz,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       dec,
  input  logic [5:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  output logic [5:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       is_zero,
  output logic       is_one
);

  localparam logic [5:0] MAX_V = 6'(MAX_MS);

  logic [5:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;

  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (clear) begin
      hour_d = 6'd0;
      min_d  = 6'd0;
      sec_d  = 6'd0;
    end else if (load) begin
      hour_d = load_hour;
      min_d  = clamp_ms(load_min, MAX_V);
      sec_d  = clamp_ms(load_sec, MAX_V);
    end else if (dec) begin
      // Borrow chain; a decrement at 00:00:00 leaves the time untouched.
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != 6'd0) begin
        sec_d = MAX_V;
        min_d = min_q - 6'd1;
      end else if (hour_q != 6'd0) begin
        sec_d  = MAX_V;
        min_d  = MAX_V;
        hour_d = hour_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk_500Hz) begin
    if (!rst_n) begin
      hour_q <= 6'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
    end
  end

  assign hour    = hour_q;
  assign min     = min_q;
  assign sec     = sec_q;
  assign is_zero = (hour_q == 6'd0) && (min_q == 6'd0) && (sec_q == 6'd0);
  assign is_one  = (hour_q == 6'd0) && (min_q == 6'd0) && (sec_q == 6'd1);

endmodule

// File: rtl/countdown_timer_module.sv
// -----------------------------------------------------------------------------
// countdown_timer_module
// Countdown engine for timed-run modes: loads a preset h:m:s on start,
// decrements once per TICKS_PER_SEC clocks, pauses/resumes, pulses done at
// expiry.
//   clk_500Hz : timing clock
//   rst_n     : synchronous active-low reset
//   bus       : slave side of countdown_timer_module_if (commands, preset,
//               remaining time, need_count_down, done)
// -----------------------------------------------------------------------------
module countdown_timer_module
  import countdown_timer_module_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT,
  parameter int MAX_MS        = MAX_MS_DEFAULT
) (
  input  logic                     clk_500Hz,
  input  logic                     rst_n,
  countdown_timer_module_if.slave  bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          need_q, need_d;

  logic       cnt_clear, cnt_load, cnt_dec;
  logic       cnt_is_zero, cnt_is_one;
  logic       preset_zero;
  logic [5:0] cnt_hour, cnt_min, cnt_sec;

  // Clamping never changes whether a field is zero, so the raw preset suffices.
  assign preset_zero = (bus.load_hour == 6'd0) && (bus.load_min == 6'd0) &&
                       (bus.load_sec == 6'd0);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (bus.abort) begin
      state_d   = IDLE;
      presc_d   = '0;
      cnt_clear = 1'b1;
    end else if (bus.start) begin
      presc_d  = '0;
      cnt_load = 1'b1;
      state_d  = preset_zero ? DONE : RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.pause) begin
            // Prescaler freezes so the partial second survives the pause.
            state_d = PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            cnt_dec = 1'b1;
            if (cnt_is_one || cnt_is_zero) begin
              state_d = DONE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (!bus.pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
        default: begin
        end
      endcase
    end
    need_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_500Hz) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
      need_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      need_q  <= need_d;
    end
  end

  countdown_timer_module_hms_down_counter #(
    .MAX_MS(MAX_MS)
  ) u_hms (
    .clk_500Hz (clk_500Hz),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .load_hour (bus.load_hour),
    .load_min  (bus.load_min),
    .load_sec  (bus.load_sec),
    .hour      (cnt_hour),
    .min       (cnt_min),
    .sec       (cnt_sec),
    .is_zero   (cnt_is_zero),
    .is_one    (cnt_is_one)
  );

  assign bus.count_down_hour = cnt_hour;
  assign bus.count_down_min  = cnt_min;
  assign bus.count_down_sec  = cnt_sec;
  assign bus.need_count_down = need_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_countdown_timer_module.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer_module
// Self-checking bench: a reference model tracks the remaining time as a total
// number of seconds plus a count of active clocks, and every cycle the DUT
// outputs are compared against it. Directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_countdown_timer_module;
  localparam int T = 4;

  logic clk_500Hz = 1'b0;
  logic rst_n     = 1'b0;

  countdown_timer_module_if bus();

  countdown_timer_module #(
    .TICKS_PER_SEC(T),
    .MAX_MS(59)
  ) dut (
    .clk_500Hz (clk_500Hz),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_remain = 0;  // remaining time in seconds
  int m_phase  = 0;  // active clocks since the last second boundary
  bit m_active = 0;  // countdown in progress (running or paused)
  bit m_paused = 0;
  bit m_done   = 0;

  function automatic int clamp59(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_step(input bit r, input bit s, input bit a, input bit p,
                            input int lh, input int lm, input int ls);
    if (!r) begin
      m_remain = 0; m_phase = 0; m_active = 0; m_paused = 0; m_done = 0;
    end else if (a) begin
      m_remain = 0; m_phase = 0; m_active = 0; m_paused = 0; m_done = 0;
    end else if (s) begin
      m_remain = lh * 3600 + clamp59(lm) * 60 + clamp59(ls);
      m_phase  = 0;
      m_paused = 0;
      m_done   = (m_remain == 0);
      m_active = (m_remain != 0);
    end else if (m_active) begin
      m_done = 0;
      if (m_paused) begin
        m_paused = p;
      end else if (p) begin
        m_paused = 1;
      end else begin
        m_phase++;
        if (m_phase == T) begin
          m_phase = 0;
          m_remain--;
          if (m_remain == 0) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end
    end else begin
      m_done   = 0;
      m_remain = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit r, input bit s, input bit a, input bit p,
                       input int lh, input int lm, input int ls);
    int eh, em, es;
    rst_n         = r;
    bus.start     = s;
    bus.abort     = a;
    bus.pause     = p;
    bus.load_hour = 6'(lh);
    bus.load_min  = 6'(lm);
    bus.load_sec  = 6'(ls);
    model_step(r, s, a, p, lh, lm, ls);
    @(negedge clk_500Hz);
    eh = m_remain / 3600;
    em = (m_remain % 3600) / 60;
    es = m_remain % 60;
    n_checks++;
    if (int'(bus.count_down_hour) == eh && int'(bus.count_down_min) == em &&
        int'(bus.count_down_sec) == es && bus.need_count_down == m_active &&
        bus.done == m_done) begin
      n_pass++;
    end else begin
      $display("FAIL cycle_compare t=%0t: got %0d:%0d:%0d need=%0b done=%0b, expected %0d:%0d:%0d need=%0b done=%0b",
               $time, bus.count_down_hour, bus.count_down_min, bus.count_down_sec,
               bus.need_count_down, bus.done, eh, em, es, m_active, m_done);
    end
  endtask

  task automatic idle(input int n, input bit p = 0);
    for (int i = 0; i < n; i++)
      cycle(1, 0, 0, p, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
  endtask

  task automatic check_zero(input string name);
    check({name, "_hour"}, bus.count_down_hour, 0);
    check({name, "_min"},  bus.count_down_min, 0);
    check({name, "_sec"},  bus.count_down_sec, 0);
    check({name, "_need"}, bus.need_count_down, 0);
    check({name, "_done"}, bus.done, 0);
  endtask

  initial begin
    bit seen;
    int cnt;
    bit r, s, a, p;
    int lh, lm, ls;

    bus.start = 0; bus.abort = 0; bus.pause = 0;
    bus.load_hour = 0; bus.load_min = 0; bus.load_sec = 0;
    @(negedge clk_500Hz);

    // Reset
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 5, 5, 5);
    check_zero("reset");

    // 0:01:02 full run
    cycle(1, 1, 0, 0, 0, 1, 2);
    check("need_after_start", bus.need_count_down, 1);
    idle(4);
    check("min_after_4", bus.count_down_min, 1);
    check("sec_after_4", bus.count_down_sec, 1);
    idle(8);
    check("min_after_12", bus.count_down_min, 0);
    check("sec_after_12", bus.count_down_sec, 59);
    idle(236);
    check("done_at_248", bus.done, 1);
    check("need_at_248", bus.need_count_down, 0);
    check("sec_at_248", bus.count_down_sec, 0);
    idle(1);
    check("done_one_cycle", bus.done, 0);

    // Hour borrow and clamp
    cycle(1, 1, 0, 0, 1, 0, 0);
    idle(4);
    check("borrow_hour", bus.count_down_hour, 0);
    check("borrow_min", bus.count_down_min, 59);
    check("borrow_sec", bus.count_down_sec, 59);
    cycle(1, 1, 0, 0, 0, 63, 60);
    check("clamp_min", bus.count_down_min, 59);
    check("clamp_sec", bus.count_down_sec, 59);
    cycle(1, 0, 1, 0, 0, 0, 0);
    check_zero("abort_after_clamp");

    // Pause
    cycle(1, 1, 0, 0, 0, 0, 5);
    idle(1);
    idle(10, 1);
    check("sec_frozen", bus.count_down_sec, 5);
    check("need_in_pause", bus.need_count_down, 1);
    seen = 0;
    cnt  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle(1);
      cnt++;
      if (bus.done) seen = 1;
    end
    check("pause_expiry_seen", seen, 1);
    check("pause_expiry_cycles", cnt, 20);

    // Zero preset, abort+start
    cycle(1, 1, 0, 0, 0, 0, 0);
    check("zero_start_done", bus.done, 1);
    check("zero_start_need", bus.need_count_down, 0);
    idle(1);
    check("zero_start_done_clr", bus.done, 0);
    cycle(1, 1, 1, 0, 0, 0, 9);
    check_zero("abort_with_start");
    idle(2);

    // Restart mid-count, then abort
    cycle(1, 1, 0, 0, 0, 0, 5);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle(1);
      if (m_remain == 3) seen = 1;
    end
    check("reach_3", seen, 1);
    idle(2);
    cycle(1, 1, 0, 0, 0, 0, 9);
    check("reload_9", bus.count_down_sec, 9);
    idle(3);
    check("presc_restart_hold", bus.count_down_sec, 9);
    idle(1);
    check("presc_restart_tick", bus.count_down_sec, 8);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      idle(1);
      if (m_remain == 2) seen = 1;
    end
    check("reach_2", seen, 1);
    cycle(1, 0, 1, 0, 0, 0, 0);
    check_zero("abort_mid");
    idle(5);

    // Reset mid-run
    cycle(1, 1, 0, 0, 0, 0, 30);
    idle(6);
    cycle(0, 0, 0, 1, 3, 3, 3);
    check_zero("reset_mid");
    for (int i = 0; i < 10; i++) idle(1, 1'(i % 3 == 0));
    check("need_after_reset", bus.need_count_down, 0);

    // Randomized traffic
    p = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 499) != 0);
      s = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) p = ~p;
      if ($urandom_range(0, 1) == 0) begin
        lh = 0; lm = 0; ls = $urandom_range(0, 6);
      end else begin
        lh = $urandom_range(0, 63); lm = $urandom_range(0, 63); ls = $urandom_range(0, 63);
      end
      cycle(r, s, a, p, lh, lm, ls);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
